detect_count_display: RTL and testbench

// Downstream stage of the sequence detector: consumes its detect level, counts

---
 rtl/detect_count_display.sv | 146 ++++++++++++++
 tb/tb_detect_count_display.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/detect_count_display.sv
`default_nettype none
// ============================================================================
//  Module   : detect_count_display
//  Brief    : Counts rising detect events as a decimal digit, drives a
//             7-segment display with a stretched decimal point and a sticky
//             overflow flag.
//  Revision : 1.0  initial release
// ============================================================================
module detect_count_display #(
    parameter int HOLD_CYCLES = 4,
    parameter int DIGIT_MAX   = 9,
    parameter int WRAP        = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       det_in,
    input  logic       clr,
    output logic [7:0] seg_out,
    output logic       ovf_out
);

    localparam int                   c_timer_w    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [c_timer_w-1:0] c_timer_load = c_timer_w'(HOLD_CYCLES - 1);
    localparam logic [c_timer_w-1:0] c_timer_one  = c_timer_w'(1);
    localparam logic [c_timer_w-1:0] c_timer_zero = '0;
    localparam logic [3:0]           c_digit_max  = 4'(DIGIT_MAX);
    localparam logic [7:0]           c_seg_reset  = 8'h3F;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_timer_w-1:0] r_timer;
    logic [c_timer_w-1:0] w_timer_nxt;
    logic                 r_det_q;
    logic [3:0]           r_count;
    logic [3:0]           w_count_nxt;
    logic                 r_ovf;
    logic                 w_ovf_nxt;
    logic [7:0]           r_seg;
    logic [7:0]           w_seg_nxt;
    logic                 w_event;
    logic                 w_at_max;

    // Segment bit n-1 is segment n of the digit diagram; DP is handled separately.
    function automatic logic [6:0] f_digit_seg(input logic [3:0] digit);
        logic [6:0] seg;
        seg = 7'h00;
        case (digit)
            4'd0:    seg = 7'h3F;
            4'd1:    seg = 7'h03;
            4'd2:    seg = 7'h76;
            4'd3:    seg = 7'h67;
            4'd4:    seg = 7'h4B;
            4'd5:    seg = 7'h6D;
            4'd6:    seg = 7'h7D;
            4'd7:    seg = 7'h07;
            4'd8:    seg = 7'h7F;
            4'd9:    seg = 7'h6F;
            default: seg = 7'h00;
        endcase
        return seg;
    endfunction

    assign w_event  = det_in & ~r_det_q;
    assign w_at_max = (r_count == c_digit_max);

    // Count and overflow; clear discards a same-cycle event.
    always_comb begin
        w_count_nxt = r_count;
        w_ovf_nxt   = r_ovf;
        if (clr) begin
            w_count_nxt = 4'd0;
            w_ovf_nxt   = 1'b0;
        end else if (w_event) begin
            if (w_at_max) begin
                w_ovf_nxt = 1'b1;
                if (WRAP != 0) begin
                    w_count_nxt = 4'd0;
                end
            end else begin
                w_count_nxt = r_count + 4'd1;
            end
        end
    end

    // DP stretch FSM: an event always (re)loads the hold timer.
    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = r_timer;
        if (clr) begin
            w_state_nxt = ST_IDLE;
            w_timer_nxt = c_timer_zero;
        end else if (w_event) begin
            w_state_nxt = ST_HOLD;
            w_timer_nxt = c_timer_load;
        end else begin
            case (r_state)
                ST_HOLD: begin
                    if (r_timer == c_timer_zero) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_timer_nxt = r_timer - c_timer_one;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    assign w_seg_nxt = {(w_state_nxt == ST_HOLD), f_digit_seg(w_count_nxt)};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_timer <= c_timer_zero;
        end else begin
            r_state <= w_state_nxt;
            r_timer <= w_timer_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_det_q <= 1'b0;
            r_count <= 4'd0;
            r_ovf   <= 1'b0;
            r_seg   <= c_seg_reset;
        end else begin
            r_det_q <= det_in;
            r_count <= w_count_nxt;
            r_ovf   <= w_ovf_nxt;
            r_seg   <= w_seg_nxt;
        end
    end

    assign seg_out = r_seg;
    assign ovf_out = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_detect_count_display.sv
`default_nettype none
// ============================================================================
//  Module   : tb_detect_count_display
//  Brief    : Directed self-checking bench for detect_count_display, with a
//             wrapping and a saturating instance sharing one stimulus.
//  Revision : 1.0  initial release
// ============================================================================
module tb_detect_count_display;

    logic       clk;
    logic       rst_n;
    logic       det_in;
    logic       clr;
    logic [7:0] seg_wrap;
    logic       ovf_wrap;
    logic [7:0] seg_sat;
    logic       ovf_sat;

    int checks;
    int errors;

    // Digit patterns 0..9 without DP.
    logic [7:0] c_digit [10];

    detect_count_display #(.HOLD_CYCLES(4), .DIGIT_MAX(9), .WRAP(1)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .det_in  (det_in),
        .clr     (clr),
        .seg_out (seg_wrap),
        .ovf_out (ovf_wrap)
    );

    detect_count_display #(.HOLD_CYCLES(4), .DIGIT_MAX(9), .WRAP(0)) dut_sat (
        .clk     (clk),
        .rst_n   (rst_n),
        .det_in  (det_in),
        .clr     (clr),
        .seg_out (seg_sat),
        .ovf_out (ovf_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    initial begin
        c_digit[0] = 8'h3F; c_digit[1] = 8'h03; c_digit[2] = 8'h76; c_digit[3] = 8'h67;
        c_digit[4] = 8'h4B; c_digit[5] = 8'h6D; c_digit[6] = 8'h7D; c_digit[7] = 8'h07;
        c_digit[8] = 8'h7F; c_digit[9] = 8'h6F;
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        det_in = 1'b0;
        clr    = 1'b0;

        // Reset state
        #12;
        check("reset_seg", seg_wrap, 8'h3F);
        check("reset_ovf", {7'd0, ovf_wrap}, 8'h00);
        tick();
        rst_n = 1'b1;
        tick();
        check("idle_seg", seg_wrap, 8'h3F);

        // Single one-cycle hit: DP for four clocks
        det_in = 1'b1;
        tick();
        check("hit_seg", seg_wrap, 8'h83);
        det_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("hit_dp%0d", i + 2), seg_wrap, 8'h83);
        end
        tick();
        check("hit_dp_off", seg_wrap, 8'h03);

        // Held level counts once, re-arms after a low cycle
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("clr_seg", seg_wrap, 8'h3F);
        det_in = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        check("held_once", seg_wrap, 8'h03);
        det_in = 1'b0;
        tick();
        check("held_drop", seg_wrap, 8'h03);
        det_in = 1'b1;
        tick();
        check("rearm_seg", seg_wrap, 8'hF6);
        det_in = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("rearm_dp_off", seg_wrap, 8'h76);

        // Ten separated hits: wrap versus saturate
        clr = 1'b1;
        tick();
        clr = 1'b0;
        for (int h = 1; h <= 10; h++) begin
            det_in = 1'b1;
            tick();
            check($sformatf("wrap_hit%0d", h), seg_wrap, 8'h80 | c_digit[h % 10]);
            check($sformatf("sat_hit%0d", h), seg_sat, 8'h80 | c_digit[(h > 9) ? 9 : h]);
            if (h == 9) check("ovf_before_wrap", {7'd0, ovf_wrap}, 8'h00);
            det_in = 1'b0;
            tick();
        end
        check("wrap_ovf", {7'd0, ovf_wrap}, 8'h01);
        check("sat_ovf", {7'd0, ovf_sat}, 8'h01);
        for (int i = 0; i < 3; i++) tick();
        check("wrap_final", seg_wrap, 8'h3F);
        check("sat_final", seg_sat, 8'h6F);

        // Asynchronous reset mid-cycle, no clock edge needed
        #2;
        rst_n = 1'b0;
        #1;
        check("async_seg", seg_wrap, 8'h3F);
        check("async_ovf", {7'd0, ovf_wrap}, 8'h00);
        check("async_sat_seg", seg_sat, 8'h3F);
        tick();
        rst_n = 1'b1;

        // Retrigger every two clocks keeps DP lit
        for (int h = 1; h <= 3; h++) begin
            det_in = 1'b1;
            tick();
            check($sformatf("retrig_hit%0d", h), seg_wrap, 8'h80 | c_digit[h]);
            det_in = 1'b0;
            tick();
            check($sformatf("retrig_gap%0d", h), {7'd0, seg_wrap[7]}, 8'h01);
        end
        tick();
        check("retrig_tail1", {7'd0, seg_wrap[7]}, 8'h01);
        tick();
        check("retrig_tail2", {7'd0, seg_wrap[7]}, 8'h01);
        tick();
        check("retrig_off", seg_wrap, 8'h67);

        // Clear wins over a same-cycle event at count 5
        for (int h = 4; h <= 5; h++) begin
            det_in = 1'b1;
            tick();
            det_in = 1'b0;
            tick();
        end
        check("count5", seg_wrap[6:0], 7'h6D);
        det_in = 1'b1;
        clr    = 1'b1;
        tick();
        clr = 1'b0;
        check("clr_evt_seg", seg_wrap, 8'h3F);
        check("clr_evt_ovf", {7'd0, ovf_wrap}, 8'h00);
        tick();
        check("clr_evt_held", seg_wrap, 8'h3F);
        det_in = 1'b0;
        tick();
        det_in = 1'b1;
        tick();
        check("after_clr_hit", seg_wrap, 8'h83);
        det_in = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
